mode_counter: RTL and testbench
===============================

MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter P_BASE, default 32, counter modulus; legal count range is 0..P_BASE-1; P_BASE >= 2.
REQ-002 Parameter P_BIT, default 32, count width; 2**P_BIT >= P_BASE.
REQ-003 Parameter P_STEP_BIT, default 8, step width; P_STEP_BIT <= P_BIT.
REQ-004 clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  advance count by step this cycle.
REQ-007 up_dw  in  1  direction: 1 = up, 0 = down.
REQ-008 mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap).
REQ-009 step  in  P_STEP_BIT  increment/decrement magnitude.
REQ-010 clear  in  1  synchronous clear to 0.
REQ-011 wenable  in  1  load request.
REQ-012 wcount  in  P_BIT  load value.
REQ-013 cmp_value  in  P_BIT  compare value.
REQ-014 count  out  P_BIT  registered count.
REQ-015 carry  out  1  registered one-cycle boundary pulse.
REQ-016 match  out  1  registered one-cycle compare pulse.
REQ-017 done  out  1  registered; high while one-shot is halted.
REQ-018 err  out  1  registered one-cycle error pulse.

Function
REQ-019 Per-cycle priority: clear > valid load > enable step; an invalid load does not block stepping.
REQ-020 A load is valid when wenable=1 and wcount < P_BASE; count <= wcount, state <= RUN, carry=0.
REQ-021 An invalid load (wenable=1, wcount >= P_BASE) leaves count unchanged by the load and pulses err next cycle.
REQ-022 Stepping happens only in state RUN with enable=1; step=0 holds count with no carry.
REQ-023 A step with step >= P_BASE holds count and pulses err.
REQ-024 Arithmetic is done at P_BIT+1 bits; no intermediate overflow at any P_BIT.
REQ-025 Up, count+step < P_BASE: count <= count+step.
REQ-026 Up crossing, wrap mode: count <= count+step-P_BASE, carry=1.
REQ-027 Up crossing, saturate or one-shot: count <= P_BASE-1; carry=1 only if count was not already P_BASE-1.
REQ-028 Down, count >= step: count <= count-step.
REQ-029 Down crossing (count < step), wrap mode: count <= count+P_BASE-step, carry=1.
REQ-030 Down crossing, saturate or one-shot: count <= 0; carry=1 only if count was not already 0.
REQ-031 One-shot: landing exactly on the terminal value (P_BASE-1 up, 0 down) counts as a crossing.
REQ-032 FSM has states RUN and HALT; RUN->HALT on a one-shot crossing; HALT->RUN only on clear or valid load.
REQ-033 In HALT, enable is ignored, count holds and done=1.
REQ-034 match=1 in the cycle count first shows cmp_value after an update (load, clear or step); a held value gives no repeat pulse.
REQ-035 count, carry, match and err update on the same edge; latency from input to output is 1 cycle.
REQ-036 A mode change takes effect on the next step; a mode change alone does not exit HALT.

Reset
REQ-037 reset=1 asynchronously forces count=0, carry=0, match=0, done=0, err=0 and state RUN.
REQ-038 Outputs remain at reset values while reset is high; operation resumes on the first rising edge after deassertion.

Structure
REQ-039 Package counter_pkg holds the mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the RUN/HALT state encoding.
REQ-040 The next-count and crossing arithmetic lives in one combinational sub-module, mode_counter_next, instantiated once.

Verification (P_BASE=10, P_BIT=8, P_STEP_BIT=4)
REQ-041 Wrap up: count=8, step=3, up, enable -> count=1, carry=1 for 1 cycle.
REQ-042 Wrap down: count=1, step=3, down -> count=8, carry=1; then step=12 -> count 8 held, err=1.
REQ-043 Saturate up: count=8, step=3 -> count=9, carry=1; next enable -> count=9, carry=0.
REQ-044 One-shot down: load 2, step=1 -> count 1 then 0, carry=1, done=1; more enables hold 0; load 5 -> count=5, done=0.
REQ-045 Invalid load: count=4, wenable=1, wcount=12, enable, step=1, up -> count=5, err=1. Match: cmp_value=6, next step -> match=1 once.
REQ-046 Reset mid-run: reset pulsed asynchronously between edges at count=7 -> count=0 and all flags 0 immediately, before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg : mode and FSM state encodings shared by the mode_counter slice
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mode_counter_next.sv
// ---------------------------------------------------------------------------
// mode_counter_next : combinational next-count, boundary and halt evaluation
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mode_counter_next
  import counter_pkg::*;
#(
  parameter int P_BASE     = 32,
  parameter int P_BIT      = 32,
  parameter int P_STEP_BIT = 8
) (
  input  logic [P_BIT-1:0]      count_i,
  input  logic [P_STEP_BIT-1:0] step_i,
  input  logic                  up_dw_i,
  input  logic [1:0]            mode_i,
  output logic [P_BIT-1:0]      next_count_o,
  output logic                  carry_o,
  output logic                  halt_o,
  output logic                  step_err_o
);

  localparam logic [P_BIT:0] c_base = (P_BIT+1)'(P_BASE);
  localparam logic [P_BIT:0] c_top  = c_base - 1'b1;

  // One extra bit keeps count+step and count+base-step free of overflow.
  logic [P_BIT:0] w_cnt;
  logic [P_BIT:0] w_stp;
  logic [P_BIT:0] w_sum;
  logic           w_oneshot;
  logic           w_clamp;
  logic           w_cross;

  always_comb begin
    w_cnt        = {1'b0, count_i};
    w_stp        = '0;
    w_stp[P_STEP_BIT-1:0] = step_i;
    w_sum        = w_cnt + w_stp;
    w_oneshot    = (mode_i == MODE_ONESHOT);
    w_clamp      = (mode_i == MODE_SAT) || w_oneshot;
    w_cross      = 1'b0;
    next_count_o = count_i;
    carry_o      = 1'b0;
    halt_o       = 1'b0;
    step_err_o   = 1'b0;

    if (w_stp >= c_base) begin
      step_err_o = 1'b1;
    end else if (w_stp != '0) begin
      if (up_dw_i) begin
        // One-shot treats landing on the terminal value as a crossing.
        w_cross = w_oneshot ? (w_sum >= c_top) : (w_sum >= c_base);
        if (!w_cross) begin
          next_count_o = P_BIT'(w_sum);
        end else if (w_clamp) begin
          next_count_o = P_BIT'(c_top);
          carry_o      = (w_cnt != c_top);
          halt_o       = w_oneshot;
        end else begin
          next_count_o = P_BIT'(w_sum - c_base);
          carry_o      = 1'b1;
        end
      end else begin
        w_cross = w_oneshot ? (w_cnt <= w_stp) : (w_cnt < w_stp);
        if (!w_cross) begin
          next_count_o = P_BIT'(w_cnt - w_stp);
        end else if (w_clamp) begin
          next_count_o = '0;
          carry_o      = (w_cnt != '0);
          halt_o       = w_oneshot;
        end else begin
          next_count_o = P_BIT'(w_cnt + c_base - w_stp);
          carry_o      = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mode_counter.sv
// ---------------------------------------------------------------------------
// mode_counter : modulo up/down counter with wrap, saturate and one-shot modes
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mode_counter
  import counter_pkg::*;
#(
  parameter int P_BASE     = 32,
  parameter int P_BIT      = 32,
  parameter int P_STEP_BIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_dw,
  input  logic [1:0]            mode,
  input  logic [P_STEP_BIT-1:0] step,
  input  logic                  clear,
  input  logic                  wenable,
  input  logic [P_BIT-1:0]      wcount,
  input  logic [P_BIT-1:0]      cmp_value,
  output logic [P_BIT-1:0]      count,
  output logic                  carry,
  output logic                  match,
  output logic                  done,
  output logic                  err
);

  localparam logic [P_BIT:0] c_base = (P_BIT+1)'(P_BASE);

  state_t           state_q, state_d;
  logic [P_BIT-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             match_q, match_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  logic [P_BIT-1:0] w_next_count;
  logic             w_next_carry;
  logic             w_next_halt;
  logic             w_step_err;
  logic             w_load_ok;

  mode_counter_next #(
    .P_BASE     (P_BASE),
    .P_BIT      (P_BIT),
    .P_STEP_BIT (P_STEP_BIT)
  ) u_next (
    .count_i      (count_q),
    .step_i       (step),
    .up_dw_i      (up_dw),
    .mode_i       (mode),
    .next_count_o (w_next_count),
    .carry_o      (w_next_carry),
    .halt_o       (w_next_halt),
    .step_err_o   (w_step_err)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    carry_d   = 1'b0;
    w_load_ok = wenable && ({1'b0, wcount} < c_base);
    // A rejected load still reports, but never blocks the step below.
    err_d     = wenable && !w_load_ok;

    if (clear) begin
      count_d = '0;
      state_d = RUN;
    end else if (w_load_ok) begin
      count_d = wcount;
      state_d = RUN;
    end else if (state_q == RUN && enable) begin
      count_d = w_next_count;
      carry_d = w_next_carry;
      if (w_step_err) err_d = 1'b1;
      if (w_next_halt) state_d = HALT;
    end

    match_d = (count_d == cmp_value) && (count_d != count_q);
    done_d  = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      count_q <= '0;
      carry_q <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      match_q <= match_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign match = match_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mode_counter.sv
// ---------------------------------------------------------------------------
// tb_mode_counter : directed and randomized checks of mode_counter
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mode_counter;

  localparam int BASE = 10;
  localparam int BW   = 8;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          reset, enable, up_dw, clear, wenable;
  logic [1:0]    mode;
  logic [SW-1:0] step;
  logic [BW-1:0] wcount, cmp_value, count;
  logic          carry, match, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: plain integers, advanced by the counting rules.
  int m_cnt;
  bit m_halt;
  int e_cnt;
  bit e_carry, e_match, e_done, e_err;

  always #5 clk = ~clk;

  mode_counter #(.P_BASE(BASE), .P_BIT(BW), .P_STEP_BIT(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dw(up_dw), .mode(mode),
    .step(step), .clear(clear), .wenable(wenable), .wcount(wcount),
    .cmp_value(cmp_value), .count(count), .carry(carry), .match(match),
    .done(done), .err(err)
  );

  task automatic idle();
    enable = 0; clear = 0; wenable = 0; step = '0; wcount = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int v);
    idle(); wenable = 1; wcount = BW'(v); tick(); idle();
  endtask

  task automatic do_step(input bit up, input int s);
    idle(); enable = 1; up_dw = up; step = SW'(s); tick(); idle();
  endtask

  task automatic model_eval();
    int raw, term;
    bit reached, over;
    e_cnt = m_cnt; e_carry = 0; e_err = 0;
    if (wenable && int'(wcount) >= BASE) e_err = 1;
    if (clear) begin
      e_cnt = 0; m_halt = 0;
    end else if (wenable && int'(wcount) < BASE) begin
      e_cnt = int'(wcount); m_halt = 0;
    end else if (!m_halt && enable) begin
      if (int'(step) >= BASE) e_err = 1;
      else if (step != 0) begin
        raw = up_dw ? m_cnt + int'(step) : m_cnt - int'(step);
        if (mode == 2'd1 || mode == 2'd2) begin
          term    = up_dw ? BASE - 1 : 0;
          reached = up_dw ? (raw >= BASE - 1) : (raw <= 0);
          over    = up_dw ? (raw > BASE - 1) : (raw < 0);
          if ((mode == 2'd2) ? reached : over) begin
            e_cnt = term; e_carry = (m_cnt != term);
            if (mode == 2'd2) m_halt = 1;
          end else e_cnt = raw;
        end else begin
          e_cnt   = ((raw % BASE) + BASE) % BASE;
          e_carry = (raw < 0) || (raw >= BASE);
        end
      end
    end
    e_match = (e_cnt != m_cnt) && (e_cnt == int'(cmp_value));
    e_done  = m_halt;
    m_cnt   = e_cnt;
  endtask

  task automatic test_reset();
    idle(); up_dw = 1; mode = 2'd0; cmp_value = 8'hFF;
    reset = 1; tick(); tick();
    n_cmp++; if ({count, carry, match, done, err} !== 12'h0) begin n_bad++;
      $display("FAIL reset_outputs: got %h want 000", {count, carry, match, done, err}); end
    #2 reset = 0; tick();
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL reset_release_count: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    mode = 2'd0; cmp_value = 8'hFF;
    do_load(8);
    n_cmp++; if (count !== 8'd8) begin n_bad++; $display("FAIL wrap_load: got %0d want 8", count); end
    do_step(1, 3);
    n_cmp++; if (count !== 8'd1 || carry !== 1'b1) begin n_bad++;
      $display("FAIL wrap_up: got count=%0d carry=%b want 1/1", count, carry); end
    tick();
    n_cmp++; if (count !== 8'd1 || carry !== 1'b0) begin n_bad++;
      $display("FAIL wrap_carry_pulse: got count=%0d carry=%b want 1/0", count, carry); end
    do_step(0, 3);
    n_cmp++; if (count !== 8'd8 || carry !== 1'b1) begin n_bad++;
      $display("FAIL wrap_down: got count=%0d carry=%b want 8/1", count, carry); end
    do_step(0, 12);
    n_cmp++; if (count !== 8'd8 || err !== 1'b1 || carry !== 1'b0) begin n_bad++;
      $display("FAIL big_step_err: got count=%0d err=%b carry=%b want 8/1/0", count, err, carry); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b want 0", err); end
  endtask

  task automatic test_saturate();
    mode = 2'd1;
    do_load(8);
    do_step(1, 3);
    n_cmp++; if (count !== 8'd9 || carry !== 1'b1) begin n_bad++;
      $display("FAIL sat_up: got count=%0d carry=%b want 9/1", count, carry); end
    do_step(1, 3);
    n_cmp++; if (count !== 8'd9 || carry !== 1'b0) begin n_bad++;
      $display("FAIL sat_hold: got count=%0d carry=%b want 9/0", count, carry); end
    do_load(1); do_step(0, 4);
    n_cmp++; if (count !== 8'd0 || carry !== 1'b1 || done !== 1'b0) begin n_bad++;
      $display("FAIL sat_down: got count=%0d carry=%b done=%b want 0/1/0", count, carry, done); end
  endtask

  task automatic test_oneshot();
    mode = 2'd2;
    do_load(2);
    do_step(0, 1);
    n_cmp++; if (count !== 8'd1 || carry !== 1'b0 || done !== 1'b0) begin n_bad++;
      $display("FAIL os_first: got count=%0d carry=%b done=%b want 1/0/0", count, carry, done); end
    do_step(0, 1);
    n_cmp++; if (count !== 8'd0 || carry !== 1'b1 || done !== 1'b1) begin n_bad++;
      $display("FAIL os_land: got count=%0d carry=%b done=%b want 0/1/1", count, carry, done); end
    do_step(1, 3);
    n_cmp++; if (count !== 8'd0 || carry !== 1'b0 || done !== 1'b1) begin n_bad++;
      $display("FAIL os_halted: got count=%0d carry=%b done=%b want 0/0/1", count, carry, done); end
    mode = 2'd0; do_step(1, 2);
    n_cmp++; if (count !== 8'd0 || done !== 1'b1) begin n_bad++;
      $display("FAIL os_mode_change: got count=%0d done=%b want 0/1", count, done); end
    do_load(5);
    n_cmp++; if (count !== 8'd5 || done !== 1'b0) begin n_bad++;
      $display("FAIL os_reload: got count=%0d done=%b want 5/0", count, done); end
    mode = 2'd2; do_load(6); do_step(1, 3);
    n_cmp++; if (count !== 8'd9 || carry !== 1'b1 || done !== 1'b1) begin n_bad++;
      $display("FAIL os_up_land: got count=%0d carry=%b done=%b want 9/1/1", count, carry, done); end
    idle(); clear = 1; tick(); idle();
    n_cmp++; if (count !== 8'd0 || done !== 1'b0) begin n_bad++;
      $display("FAIL os_clear: got count=%0d done=%b want 0/0", count, done); end
  endtask

  task automatic test_invalid_load_match();
    mode = 2'd0; cmp_value = 8'hFF;
    do_load(4);
    idle(); wenable = 1; wcount = 8'd12; enable = 1; step = 4'd1; up_dw = 1; tick(); idle();
    n_cmp++; if (count !== 8'd5 || err !== 1'b1) begin n_bad++;
      $display("FAIL invalid_load: got count=%0d err=%b want 5/1", count, err); end
    cmp_value = 8'd6; do_step(1, 1);
    n_cmp++; if (count !== 8'd6 || match !== 1'b1) begin n_bad++;
      $display("FAIL match_pulse: got count=%0d match=%b want 6/1", count, match); end
    do_step(1, 0);
    n_cmp++; if (count !== 8'd6 || match !== 1'b0) begin n_bad++;
      $display("FAIL match_once: got count=%0d match=%b want 6/0", count, match); end
    cmp_value = 8'hFF;
  endtask

  task automatic test_async_reset();
    mode = 2'd0; cmp_value = 8'd7;
    do_load(7);
    n_cmp++; if (count !== 8'd7 || match !== 1'b1) begin n_bad++;
      $display("FAIL pre_reset: got count=%0d match=%b want 7/1", count, match); end
    #2 reset = 1; #1;
    n_cmp++; if ({count, carry, match, done, err} !== 12'h0) begin n_bad++;
      $display("FAIL async_reset: got %h want 000", {count, carry, match, done, err}); end
    tick();
    #2 reset = 0; tick();
    cmp_value = 8'hFF; do_load(3);
    n_cmp++; if (count !== 8'd3) begin n_bad++; $display("FAIL resume: got %0d want 3", count); end
  endtask

  task automatic test_random();
    idle(); cmp_value = 8'hFF; clear = 1; tick(); idle();
    m_cnt = 0; m_halt = 0;
    for (int i = 0; i < 400; i++) begin
      clear   = ($urandom_range(0, 24) == 0);
      wenable = ($urandom_range(0, 7) == 0);
      wcount  = BW'($urandom_range(0, 13));
      enable  = ($urandom_range(0, 3) != 0);
      up_dw   = 1'($urandom);
      mode    = 2'($urandom);
      step    = SW'(($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 6));
      cmp_value = BW'($urandom_range(0, 9));
      model_eval();
      tick();
      n_cmp++; if (int'(count) !== e_cnt) begin n_bad++;
        $display("FAIL rand_count[%0d]: got %0d want %0d", i, count, e_cnt); end
      n_cmp++; if (carry !== e_carry) begin n_bad++;
        $display("FAIL rand_carry[%0d]: got %b want %b", i, carry, e_carry); end
      n_cmp++; if (match !== e_match) begin n_bad++;
        $display("FAIL rand_match[%0d]: got %b want %b", i, match, e_match); end
      n_cmp++; if (done !== e_done) begin n_bad++;
        $display("FAIL rand_done[%0d]: got %b want %b", i, done, e_done); end
      n_cmp++; if (err !== e_err) begin n_bad++;
        $display("FAIL rand_err[%0d]: got %b want %b", i, err, e_err); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_invalid_load_match();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
